// File: rtl/btn_scan_ctrl.sv
// Scan controller for a 74HC165-style button chain: sequences PL/CE/CP, captures
// NBITS samples, debounces them and raises sticky press events plus an interrupt.
module btn_scan_ctrl #(
   parameter int unsigned NBITS       = 8,
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned PL_CYCLES   = 2,
   parameter int unsigned SCAN_PERIOD = 50000,
   parameter int unsigned DEBOUNCE    = 3,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             auto_en,
   input  logic             sr_q,
   input  logic [NBITS-1:0] clr_evt,
   output logic             sr_pl,
   output logic             sr_ce,
   output logic             sr_cp,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] raw,
   output logic [NBITS-1:0] stable,
   output logic [NBITS-1:0] press_evt,
   output logic             irq
);

   localparam int unsigned TMAX = (CLK_DIV > PL_CYCLES) ? CLK_DIV : PL_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int unsigned BW   = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int unsigned PW   = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int unsigned CW   = $clog2(DEBOUNCE + 1);

   localparam logic [TW-1:0] PL_LAST  = TW'(PL_CYCLES - 1);
   localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
   localparam logic [PW-1:0] PER_LAST = PW'(SCAN_PERIOD - 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t           state, state_d;
   logic [TW-1:0]    tmr, tmr_d;
   logic [BW-1:0]    bit_idx, bit_d;
   logic [PW-1:0]    per_cnt, per_d;
   logic             smp_en;
   logic             expired;
   logic             sample;
   logic [NBITS-1:0] shreg;
   logic [CW-1:0]    cnt   [NBITS];
   logic [CW-1:0]    cnt_d [NBITS];
   logic [NBITS-1:0] stb_d;
   logic [NBITS-1:0] rise;
   logic             pl_c, ce_c, cp_c, busy_c, done_c;

   assign expired = auto_en && (per_cnt == PER_LAST);
   assign sample  = ACTIVE_LOW ? ~sr_q : sr_q;

   // Next-state, phase timers and registered-output decode
   always_comb begin
      state_d = state;
      tmr_d   = tmr;
      bit_d   = bit_idx;
      per_d   = '0;
      smp_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start || expired) begin
               state_d = LOAD;
               tmr_d   = '0;
            end else if (auto_en) begin
               per_d = per_cnt + PW'(1);
            end
         end
         LOAD: begin
            if (tmr == PL_LAST) begin
               state_d = SHIFT_LO;
               tmr_d   = '0;
               bit_d   = '0;
            end else begin
               tmr_d = tmr + TW'(1);
            end
         end
         SHIFT_LO: begin
            if (tmr == DIV_LAST) begin
               smp_en  = 1'b1;
               state_d = SHIFT_HI;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr + TW'(1);
            end
         end
         SHIFT_HI: begin
            if (tmr == DIV_LAST) begin
               tmr_d = '0;
               if (bit_idx == BIT_LAST) begin
                  state_d = DONE;
               end else begin
                  bit_d   = bit_idx + BW'(1);
                  state_d = SHIFT_LO;
               end
            end else begin
               tmr_d = tmr + TW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      pl_c   = (state_d != LOAD);
      ce_c   = !((state_d == SHIFT_LO) || (state_d == SHIFT_HI));
      cp_c   = (state_d == SHIFT_HI);
      busy_c = (state_d != IDLE);
      done_c = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         tmr     <= '0;
         bit_idx <= '0;
         per_cnt <= '0;
      end else begin
         state   <= state_d;
         tmr     <= tmr_d;
         bit_idx <= bit_d;
         per_cnt <= per_d;
      end
   end

   // Chain strobes are decoded from the next state so they change cleanly on the clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_pl <= 1'b1;
         sr_ce <= 1'b1;
         sr_cp <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         sr_pl <= pl_c;
         sr_ce <= ce_c;
         sr_cp <= cp_c;
         busy  <= busy_c;
         done  <= done_c;
      end
   end

   // Per-bit debounce, evaluated once per completed scan
   always_comb begin
      stb_d = stable;
      for (int i = 0; i < int'(NBITS); i++) begin
         cnt_d[i] = cnt[i];
         if (state_d == DONE) begin
            if (shreg[i] != stable[i]) begin
               if (cnt[i] == DB_LAST) begin
                  stb_d[i] = ~stable[i];
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt[i] + CW'(1);
               end
            end else begin
               cnt_d[i] = '0;
            end
         end
      end
      rise = stb_d & ~stable;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg     <= '0;
         raw       <= '0;
         stable    <= '0;
         press_evt <= '0;
         irq       <= 1'b0;
         for (int i = 0; i < int'(NBITS); i++) cnt[i] <= '0;
      end else begin
         // First bit out of the chain lands in the MSB
         if (smp_en) begin
            for (int i = 0; i < int'(NBITS); i++) begin
               if (bit_idx == BW'(int'(NBITS) - 1 - i)) shreg[i] <= sample;
            end
         end
         if (state_d == DONE) raw <= shreg;
         stable <= stb_d;
         for (int i = 0; i < int'(NBITS); i++) cnt[i] <= cnt_d[i];
         // A new press in the same cycle as a clear keeps the event set
         press_evt <= (press_evt & ~clr_evt) | rise;
         irq       <= |press_evt;
      end
   end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Randomized scoreboard bench for btn_scan_ctrl with a behavioural 74HC165 chain
// and a reference model for sampling, debounce and press events.
`timescale 1ns/1ps
module tb_btn_scan_ctrl;

   localparam int NB  = 8;
   localparam int CD  = 4;
   localparam int PLC = 2;
   localparam int SP  = 100;
   localparam int DB  = 3;
   localparam bit AL  = 1'b1;
   localparam int SCAN_LEN = PLC + 2 * NB * CD + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          auto_en = 1'b0;
   logic          sr_q;
   logic [NB-1:0] clr_evt = '0;
   logic          sr_pl, sr_ce, sr_cp, busy, done, irq;
   logic [NB-1:0] raw, stable, press_evt;

   btn_scan_ctrl #(
      .NBITS(NB), .CLK_DIV(CD), .PL_CYCLES(PLC), .SCAN_PERIOD(SP),
      .DEBOUNCE(DB), .ACTIVE_LOW(AL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .sr_q(sr_q),
      .clr_evt(clr_evt), .sr_pl(sr_pl), .sr_ce(sr_ce), .sr_cp(sr_cp),
      .busy(busy), .done(done), .raw(raw), .stable(stable),
      .press_evt(press_evt), .irq(irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Chain: PL low loads the pads, CP rising edge with CE low shifts toward Q7
   logic [NB-1:0] pdata = '0;
   logic [NB-1:0] chain = '1;
   assign sr_q = chain[NB-1];
   always @(negedge sr_pl or posedge sr_cp) begin
      #1;
      if (!sr_pl) chain = pdata;
      else if (sr_cp && !sr_ce) chain = {chain[NB-2:0], 1'b1};
   end

   // Reference model: pressed pattern per scan, debounce as run length of disagreement
   typedef struct {
      int            cyc;
      logic [NB-1:0] raw;
      logic [NB-1:0] stb;
      logic [NB-1:0] evt;
   } exp_t;
   exp_t          sb[$];
   logic [NB-1:0] m_stable = '0;
   logic [NB-1:0] m_evt = '0;
   int            m_run[NB];

   task automatic model_scan(input logic [NB-1:0] s, input logic [NB-1:0] clr, input int dcyc);
      exp_t e;
      logic [NB-1:0] rose = '0;
      for (int i = 0; i < NB; i++) begin
         if (s[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] >= DB) begin
               m_stable[i] = s[i];
               m_run[i] = 0;
               rose[i] = s[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_evt = (m_evt & ~clr) | rose;
      e.cyc = dcyc; e.raw = s; e.stb = m_stable; e.evt = m_evt;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      m_stable = '0;
      m_evt = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
   endtask

   // Monitor: pops the scoreboard on every done pulse
   int   pl_lo = 0, cp_rise = 0, bad_ctl = 0;
   logic cp_prev = 1'b0;
   bit   irq_chk = 1'b0;
   logic irq_exp = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         pl_lo = 0; cp_rise = 0; irq_chk = 1'b0;
      end else begin
         if (!sr_pl) pl_lo++;
         if (sr_cp && !cp_prev) cp_rise++;
         if (!sr_pl && !sr_ce) bad_ctl++;
         if (irq_chk) begin
            chk("irq_after_done", irq, irq_exp);
            irq_chk = 1'b0;
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("raw", raw, e.raw);
               chk("stable", stable, e.stb);
               chk("press_evt", press_evt, e.evt);
               chk("pl_low_cycles", pl_lo, PLC);
               chk("cp_pulses", cp_rise, NB);
               irq_exp = |e.evt;
               irq_chk = 1'b1;
            end
            pl_lo = 0;
            cp_rise = 0;
         end
      end
      cp_prev = sr_cp;
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(posedge clk); #1;
      while (busy && n < 500) begin @(posedge clk); #1; n++; end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic scan(input logic [NB-1:0] pressed, input logic [NB-1:0] clr_done,
                       input bit track, output int t);
      wait_idle();
      pdata = pressed ^ {NB{AL}};
      start = 1'b1;
      t = cyc;
      if (track) model_scan(pressed, clr_done, t + SCAN_LEN);
      @(posedge clk); #1;
      start = 1'b0;
      if (clr_done != '0) begin
         wait_cyc(t + SCAN_LEN - 1);
         clr_evt = clr_done;
         @(posedge clk); #1;
         clr_evt = '0;
      end
   endtask

   task automatic clear(input logic [NB-1:0] mask);
      wait_idle();
      clr_evt = mask;
      m_evt = m_evt & ~mask;
      @(posedge clk); #1;
      clr_evt = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int t, a, t2, bad, reps;
      logic [NB-1:0] p, m;

      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(posedge clk); #1;
         if ({sr_pl, sr_ce, sr_cp, busy, done, irq} !== 6'b110000 ||
             raw !== '0 || stable !== '0 || press_evt !== '0) bad++;
      end
      chk("reset_idle_violations", bad, 0);

      // Single scan: buttons 7 and 0 pressed
      scan(8'h81, '0, 1'b1, t);
      chk("load_pl_low", sr_pl, 0);
      chk("load_busy", busy, 1);
      wait_cyc(t + PLC + CD);
      chk("cp_low_before_first_edge", sr_cp, 0);
      wait_cyc(t + PLC + CD + 1);
      chk("first_cp_edge", sr_cp, 1);

      // Debounce: settle, then three presses of bit 0, then a 2-scan glitch on bit 1
      repeat (2) scan(8'h00, '0, 1'b1, t);
      repeat (3) scan(8'h01, '0, 1'b1, t);
      scan(8'h03, '0, 1'b1, t);
      scan(8'h03, '0, 1'b1, t);
      scan(8'h01, '0, 1'b1, t);

      // Clear alone
      wait_idle();
      chk("evt_before_clear", press_evt, m_evt);
      clr_evt = '1;
      m_evt = '0;
      @(posedge clk); #1;
      clr_evt = '0;
      chk("clear_press_evt", press_evt, 0);
      @(posedge clk); #1;
      chk("clear_irq", irq, 0);

      // Clear racing a new press on bit 0
      repeat (3) scan(8'h00, '0, 1'b1, t);
      repeat (2) scan(8'h01, '0, 1'b1, t);
      scan(8'h01, 8'h01, 1'b1, t);

      // Randomized patterns held for a random number of scans
      for (int g = 0; g < 8; g++) begin
         p = NB'($urandom_range(0, 255));
         reps = $urandom_range(1, 4);
         for (int r = 0; r < reps; r++) begin
            m = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
            scan(p, m, 1'b1, t);
         end
         if ($urandom_range(0, 2) == 0) clear(NB'($urandom));
      end

      // Auto mode: period, start at expiry, start while busy, disable mid-scan
      wait_idle();
      p = 8'h5A;
      pdata = p ^ {NB{AL}};
      auto_en = 1'b1;
      a = cyc;
      model_scan(p, '0, a + SP - 1 + SCAN_LEN);
      model_scan(p, '0, a + SP - 1 + SCAN_LEN + (SP + SCAN_LEN));
      model_scan(p, '0, a + SP - 1 + SCAN_LEN + 2 * (SP + SCAN_LEN));
      t2 = a + SP - 1 + (SP + SCAN_LEN);
      wait_cyc(t2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_cyc(t2 + 30);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_cyc(t2 + (SP + SCAN_LEN) + 20);
      chk("auto_third_scan_busy", busy, 1);
      auto_en = 1'b0;
      wait_cyc(a + 800);
      chk("auto_queue_drained", sb.size(), 0);

      // Reset during SHIFT_HI of bit 4, then a fresh scan sequence
      chk("stable_nonzero_before_reset", (stable != '0), 1);
      scan(8'hFF, '0, 1'b0, t);
      wait_cyc(t + PLC + 1 + 4 * 2 * CD + CD + 1);
      chk("mid_scan_cp_high", sr_cp, 1);
      rst = 1'b0;
      #1;
      chk("reset_ctl", {sr_pl, sr_ce, sr_cp, busy, done}, 5'b11000);
      chk("reset_vectors", {raw, stable, press_evt, irq}, '0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) scan(8'h3C, '0, 1'b1, t);

      wait_cyc(cyc + 200);
      chk("scoreboard_empty", sb.size(), 0);
      chk("pl_ce_overlap", bad_ctl, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
